// File: rtl/ecc_pkg.sv
// Shared Hamming(38,32) SEC-DED definitions used by both the store encoder and load_module,
// so the check-bit layout can only ever change in one place.
package ecc_pkg;

  localparam int ECC_DATA_W = 32;
  localparam int ECC_PAR_W  = 7;

  // Codeword position (1..38) of data bit idx: the idx-th position that is not a power of 2.
  function automatic logic [5:0] ecc_data_pos(input int unsigned idx);
    logic [5:0]  pos;
    int unsigned cnt;
    pos = '0;
    cnt = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = 6'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [ECC_PAR_W-1:0] ecc_encode(input logic [ECC_DATA_W-1:0] data);
    logic [ECC_PAR_W-1:0] par;
    logic [5:0]           pos;
    par = '0;
    for (int unsigned i = 0; i < ECC_DATA_W; i++) begin
      pos = ecc_data_pos(i);
      for (int k = 0; k < 6; k++) begin
        if (pos[k]) par[k] = par[k] ^ data[i];
      end
    end
    par[6] = (^data) ^ (^par[5:0]);
    return par;
  endfunction

endpackage

// File: rtl/ecc_encode32.sv
// Combinational 32-bit SEC-DED check-bit generator; thin wrapper over ecc_pkg::ecc_encode.
module ecc_encode32
  import ecc_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  output logic [ECC_PAR_W-1:0]  parity
);

  assign parity = ecc_encode(data);

endmodule

// File: rtl/store_ecc_encoder.sv
// Store-side ECC encoder: encodes store words (or passes raw parity for fault injection)
// and buffers {addr, data, parity} in a small FIFO drained to the data-memory write port.
module store_ecc_encoder
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [ECC_DATA_W-1:0] in_data,
  input  logic                  special_store,
  input  logic [ECC_PAR_W-1:0]  in_parity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [ECC_DATA_W-1:0] out_data,
  output logic [ECC_PAR_W-1:0]  out_parity,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  special_pending
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ECC_PAR_W-1:0]  enc_parity_p0;
  logic [ECC_PAR_W-1:0]  parity_p0;
  logic                  push_p0;
  logic                  pop_p0;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_next;
  logic [ADDR_W-1:0]     addr_mem [DEPTH];
  logic [ECC_DATA_W-1:0] data_mem [DEPTH];
  logic [ECC_PAR_W-1:0]  par_mem  [DEPTH];
  logic [DEPTH-1:0]      spec_mem;

  // stage p0: encode on the input side
  ecc_encode32 u_encode (
    .data   (in_data),
    .parity (enc_parity_p0)
  );

  assign parity_p0 = special_store ? in_parity : enc_parity_p0;
  assign in_ready  = (occupancy != CNT_W'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push_p0   = in_valid && in_ready;
  assign pop_p0    = out_valid && out_ready;
  assign rd_next   = rd_ptr + PTR_W'(1);

  // stage p1: FIFO storage and head register
  always_ff @(posedge clk) begin
    if (push_p0) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
      par_mem[wr_ptr]  <= parity_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      spec_mem   <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      out_parity <= '0;
    end else begin
      if (push_p0) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        spec_mem[wr_ptr] <= special_store;
      end
      if (pop_p0) rd_ptr <= rd_next;
      case ({push_p0, pop_p0})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      // The head comes straight from the input when the new word becomes the only entry.
      if (push_p0 && ((occupancy == '0) || (pop_p0 && occupancy == CNT_W'(1)))) begin
        out_addr   <= in_addr;
        out_data   <= in_data;
        out_parity <= parity_p0;
      end else if (pop_p0 && occupancy > CNT_W'(1)) begin
        out_addr   <= addr_mem[rd_next];
        out_data   <= data_mem[rd_next];
        out_parity <= par_mem[rd_next];
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] rel;
    special_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(rel) < occupancy) && spec_mem[i]) special_pending = 1'b1;
    end
  end

endmodule

// File: doc/store_ecc_encoder.md
Name: store_ecc_encoder

Overview:
- Store-side counterpart of load_module. Takes 32-bit store words from the execute stage and generates the 7-bit SEC-DED check field that load_module later decodes.
- Buffers encoded {addr, data, parity} words in a small FIFO and drains them to the data-memory write port with a valid/ready handshake.
- A special_store path writes caller-supplied raw parity without encoding. This is used for fault injection, so the bench can exercise load_module's SEC/DED paths from real memory.

Parameters:
- ADDR_W, 32, store address width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 3, width of occupancy output; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  encoder can accept; high when FIFO is not full.
- in_addr  in  ADDR_W  store word address.
- in_data  in  32  store data.
- special_store  in  1  1 = bypass encoder and store in_parity verbatim.
- in_parity  in  7  raw parity, used only when special_store=1.
- out_valid  out  1  FIFO head valid to memory.
- out_ready  in  1  memory accepts head this cycle.
- out_addr  out  ADDR_W  head address.
- out_data  out  32  head data.
- out_parity  out  7  head check bits.
- occupancy  out  CNT_W  number of valid entries.
- special_pending  out  1  at least one buffered entry was a special store.

Behaviour:
- Encoding (combinational on the input side, registered into the FIFO):
  - Hamming(38,32) layout. Codeword positions run 1..38; positions 1,2,4,8,16,32 hold check bits. Data bit i occupies the i-th non-power-of-2 position in ascending order: d0=pos3, d1=pos5, d2=pos6, d3=pos7, d4=pos9, and so on.
  - parity[k], for k=0..5, is the XOR of every data bit whose position has bit k set.
  - parity[6] is the XOR of all 32 data bits and parity[5:0] (overall even parity).
  - special_store=1: parity = in_parity unchanged; data is unchanged.
- Push: in_valid && in_ready at a rising edge writes the entry into the tail. There is no combinational pass-through.
- Pop: out_valid && out_ready at a rising edge advances the head.
- out_* are driven from the head entry register. Latency is 1 cycle: a word accepted at edge N is presented from edge N onward, so out_valid is high in cycle N+1 when the FIFO was empty.
- Head values stay stable while out_valid && !out_ready. The memory may stall indefinitely.
- Full: in_ready=0 when occupancy==DEPTH, even if out_ready=1 in the same cycle. in_valid while not ready is ignored; the source must hold the request.
- Empty: out_valid=0; out_data, out_addr and out_parity hold their last value and must not be used.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged, and both pointers advance.
- Push into an empty FIFO with out_ready=1: no pop that cycle, since out_valid was 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. occupancy is the explicit counter, 0..DEPTH.
- special_pending: computed from a per-entry special flag, OR-reduced over valid entries.
- Reset, asynchronous including mid-operation:
  - pointers, occupancy and all special flags go to 0.
  - out_valid=0, in_ready=1, special_pending=0.
  - out_data, out_addr and out_parity go to 0.
  - All buffered stores are discarded.
- X on in_data while in_valid=0 must not propagate to any output.

Decomposition:
- Shared package ecc_pkg:
  - ECC_DATA_W=32, ECC_PAR_W=7.
  - The function mapping data bit index to codeword position.
  - The function ecc_encode(data) -> parity[6:0].
  - The package is shared with load_module so encoder and decoder cannot diverge.
- One sub-module: ecc_encode32, a purely combinational wrapper around ecc_encode. It is instantiated here and reusable by the bench as a reference model.
- FIFO storage stays inline.

Test Plan:
- Encode golden values:
  - data 32'h0 -> parity 7'h00.
  - 32'h1 -> 7'h43.
  - 32'h2 -> 7'h45.
  - 32'h4 -> 7'h46.
  - 32'h6 -> 7'h03.
  - Each output, fed to load_module, gives single_error=0 and DED_exception=0.
- Full/backpressure: hold out_ready=0 and push DEPTH words (addr 0..3). Then in_ready=0 and occupancy=4. A 5th in_valid is ignored. Release out_ready: words drain in order with addr 0,1,2,3.
- Simultaneous push/pop: with occupancy=2, drive in_valid=1 and out_ready=1 for 10 cycles. occupancy stays 2, no loss or duplication, and the pointers wrap cleanly.
- Special store: special_store=1, data 32'h0, in_parity 7'b0000001. out_parity=7'h01 and special_pending=1 until popped. load_module flags single_error=1 with corrected parity 7'h00.
- Reset mid-stream: with 3 entries buffered, assert rst_n=0 asynchronously between edges. out_valid and occupancy go to 0 immediately and in_ready=1. After release, the first new store appears at the head.
- Random: 10k random data words. Every out_parity matches ecc_encode32, and the order is preserved versus the scoreboard.
